// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (shift-add multiplier,
// non-restoring divider and any later iterative units).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Ceiling log2 usable in constant expressions; returns at least 1 so a
  // counter sized from it is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : arith_pkg

// File: rtl/shift_add_step.sv
// One shift-add multiply iteration: conditionally add the multiplicand into the
// high half, then shift the whole accumulator right by one bit.
module shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   acc_nxt
);

  logic [WIDTH:0]   hi_ext;
  logic [WIDTH:0]   sum;
  logic             unused_carry;

  // The carry bit is always consumed by the shift of the previous step.
  assign unused_carry = acc[2*WIDTH];

  assign hi_ext  = {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign sum     = acc[0] ? (hi_ext + {1'b0, mcand}) : hi_ext;
  assign acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};

endmodule : shift_add_step

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier retiring one multiplier bit per clock behind
// valid/ready request and result handshakes.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | iterating, one multiplier bit per cycle for WIDTH cycles
// DONE  | product on p, out_valid high until out_ready
module shift_add_mul
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_t          state;
  mul_state_t          state_nxt;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH:0]    acc;
  logic [2*WIDTH:0]    acc_step;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .acc_nxt (acc_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= x;
            acc   <= {1'b0, {WIDTH{1'b0}}, y};
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs come from registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign p         = acc[2*WIDTH-1:0];

endmodule : shift_add_mul

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: directed latency, carry, backpressure and
// reset cases, then a long random run with random request and result gaps.
module tb_shift_add_mul;
  localparam int W = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  p;

  logic [2*W:0]    s_acc;
  logic [W-1:0]    s_mcand;
  logic [2*W:0]    s_nxt;

  int              n_chk;
  int              n_err;
  int              n_acc;
  int              n_out;
  int              lat;
  bit              rnd_done;
  logic [63:0]     exp_q[$];

  shift_add_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  shift_add_step #(.WIDTH(W)) u_step_chk (
    .acc     (s_acc),
    .mcand   (s_mcand),
    .acc_nxt (s_nxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result side of the scoreboard: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("spurious_result", {1'b0, p}, 65'd0 - 65'd1);
      else chk("product", {1'b0, p}, {1'b0, exp_q.pop_front()});
    end
  end

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    x = a;
    y = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 65'(in_ready), 65'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({32'd0, a} * {32'd0, b});
      n_acc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) chk("out_timeout", 65'(out_valid), 65'd1);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_acc = 0; n_out = 0; rnd_done = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    s_acc = '0; s_mcand = '0;
    idle_cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_p", {1'b0, p}, 65'd0);

    // Single-step checks on the combinational iteration.
    s_acc = {1'b0, 32'hFFFF_FFFF, 32'h0000_0001}; s_mcand = 32'd1;
    #1 chk("step_carry", s_nxt, 65'h0_8000_0000_0000_0000);
    s_acc = {1'b0, 32'd6, 32'd4}; s_mcand = 32'hABCD_0123;
    #1 chk("step_noadd", s_nxt, 65'h0_0000_0003_0000_0002);

    // 3*5 with latency and in_ready timing.
    @(posedge clk); #1;
    out_ready = 1'b1;
    accept(32'd3, 32'd5);
    @(negedge clk);
    chk("busy_in_ready", 65'(in_ready), 65'd0);
    #1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      if (!out_valid) lat++;
    end
    lat = lat;
    chk("latency_3x5", 65'(lat), 65'd32);
    chk("p_3x5", {1'b0, p}, 65'd15);
    @(posedge clk); #1;
    chk("ready_after_R", 65'(in_ready), 65'd1);
    chk("valid_after_R", 65'(out_valid), 65'd0);

    // All ones exercises the carry on every step.
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(lat);
    chk("latency_ones", 65'(lat), 65'd32);
    chk("p_ones", {1'b0, p}, 65'h0_FFFF_FFFE_0000_0001);
    idle_cycles(1);

    // Zero operands, both orders, take the full latency.
    accept(32'd0, 32'hDEAD_BEEF);
    wait_out(lat);
    chk("latency_zero_x", 65'(lat), 65'd32);
    chk("p_zero_x", {1'b0, p}, 65'd0);
    idle_cycles(1);
    accept(32'hDEAD_BEEF, 32'd0);
    wait_out(lat);
    chk("latency_zero_y", 65'(lat), 65'd32);
    chk("p_zero_y", {1'b0, p}, 65'd0);
    idle_cycles(1);

    // Backpressure: result held, a request pulse in the window is refused.
    out_ready = 1'b0;
    accept(32'd7, 32'd9);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin x = 32'd100; y = 32'd100; in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", 65'(out_valid), 65'd1);
      chk("bp_p", {1'b0, p}, 65'd63);
      chk("bp_in_ready", 65'(in_ready), 65'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle_cycles(45);
    chk("bp_queue_empty", 65'(exp_q.size()), 65'd0);
    chk("bp_outputs", 65'(n_out), 65'(n_acc));

    // Reset in the middle of CALC discards the operation.
    accept(32'h1234_5678, 32'h9ABC_DEF0);
    idle_cycles(9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_acc--;
    @(negedge clk);
    chk("mid_rst_in_ready", 65'(in_ready), 65'd1);
    chk("mid_rst_out_valid", 65'(out_valid), 65'd0);
    chk("mid_rst_p", {1'b0, p}, 65'd0);
    idle_cycles(45);
    chk("mid_rst_no_result", 65'(n_out), 65'(n_acc));
    accept(32'd2, 32'd4);
    wait_out(lat);
    chk("p_2x4", {1'b0, p}, 65'd8);
    idle_cycles(2);

    // Random back-to-back traffic with gaps on both sides.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          idle_cycles($urandom_range(0, 2));
          accept($urandom, $urandom);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done || exp_q.size() != 0) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          if ($time > 2900us) break;
        end
        out_ready = 1'b1;
      end
    join
    idle_cycles(3);
    chk("rnd_queue_empty", 65'(exp_q.size()), 65'd0);
    chk("rnd_one_per_req", 65'(n_out), 65'(n_acc));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_shift_add_mul

// File: doc/shift_add_mul.md
# shift_add_mul

Sequential unsigned shift-add multiplier, the multiply counterpart of the arithmetic unit's non-restoring divider. It takes two WIDTH-bit unsigned operands and produces the full 2*WIDTH-bit product. The multiplier retires one multiplier bit per clock, so latency is fixed. It sits behind a valid/ready request interface and a valid/ready result interface, so it can be dropped into the same datapath slot as the divider.

## Interface
- WIDTH, 32: operand width in bits; the product is 2*WIDTH bits wide. Legal range is 2 or more.
- clk  in  1  single clock; every register updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  the operand pair x, y is valid this cycle.
- in_ready  out  1  the block can accept operands; high only in IDLE.
- x  in  WIDTH  multiplicand, unsigned.
- y  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  p holds a finished product; high only in DONE.
- out_ready  in  1  the consumer accepts p.
- p  out  2*WIDTH  product x*y, unsigned.

## Operation
- Datapath registers:
  - mcand (WIDTH): latched x.
  - acc (2*WIDTH+1): acc[2*WIDTH] is the carry bit, the next WIDTH bits are the high half, the low WIDTH bits are the low half.
  - cnt: counts 0..WIDTH-1, width $clog2(WIDTH).
- State machine with three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mcand←x, acc←{1'b0, WIDTH'b0, y}, cnt←0, go to CALC.
- CALC, one step per cycle:
  - If acc[0]=1, add mcand to the high half: sum = {1'b0, acc[2W-1:W]} + mcand, which is W+1 bits.
  - Then shift the whole of {sum, acc[W-1:0]} right by one bit into acc.
  - cnt←cnt+1.
  - On the step where cnt==WIDTH-1, go to DONE.
  - in_valid is ignored throughout CALC, because in_ready=0.
- DONE:
  - out_valid=1 and p=acc[2W-1:0], held stable.
  - On out_ready, go to IDLE.
  - While out_ready=0, p and out_valid hold indefinitely.
- No early termination. Zero operands take the same latency as any other operands.
- Arithmetic:
  - The product is exact modulo nothing; there is no overflow, since x*y < 2^(2W).
  - The carry bit is consumed by the following shift, so acc[2W] reads 0 after every step.
- Reset: when rst_n=0 at a clock edge:
  - state←IDLE, cnt←0, acc←0, mcand←0.
  - Resulting outputs: in_ready=1, out_valid=0, p=0.
  - Reset wins over any handshake in the same cycle.
  - Reset in the middle of CALC or DONE discards the operation; no out_valid is produced for it.

## Timing
- Accept edge E0: the edge where in_valid&&in_ready.
- CALC steps happen on edges E0+1 through E0+WIDTH.
- out_valid rises after edge E0+WIDTH, so latency from accept to out_valid is WIDTH cycles.
- Result handshake edge R: the edge where out_valid&&out_ready. in_ready rises after R.
- Next possible accept is R+1. Throughput is one product per WIDTH+2 cycles when out_ready is held high.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- p is driven from acc and is valid only while out_valid=1. Its value outside DONE is don't-care, except that it must be 0 after reset.

## Structure
- Shared package arith_pkg:
  - state enum mul_state_t {IDLE, CALC, DONE}, 2 bits, encoding 0/1/2.
  - the function clog2 helper, used for the cnt width.
  - The divider and any future sequential divider reuse this package.
- One sub-module, shift_add_step:
  - Purely combinational, one iteration of the algorithm.
  - Inputs: acc and mcand. Output: next acc.
  - Lets the bench check a single step in isolation, and allows unrolling later by instantiating multiple copies per cycle.
- Top: FSM, cnt, and registers.

## Test plan
- WIDTH=32, x=3, y=5, out_ready=1:
  - in_ready drops after E0.
  - out_valid rises exactly 32 cycles later with p=15.
  - in_ready returns the cycle after the handshake.
- x=y=0xFFFFFFFF: p=0xFFFFFFFE_00000001, which exercises the carry bit on every step.
- x=0, y=0xDEADBEEF, then x=0xDEADBEEF, y=0:
  - both give p=0 with the full 32-cycle latency.
  - swapped operands give an identical product.
- Backpressure: x=7, y=9, out_ready held low for 10 cycles after out_valid:
  - p=63 and out_valid are held stable.
  - in_ready stays 0.
  - in_valid pulsed with other operands during this window is not accepted.
- Reset mid-operation: assert rst_n=0 at cycle E0+10. Next cycle shows in_ready=1, out_valid=0, p=0, and no spurious result follows. A new request x=2, y=4 then yields p=8.
- Random back-to-back: 1000 random operand pairs with random in_valid and out_ready gaps. p must equal the 64-bit x*y, results must arrive in order, and there must be exactly one out_valid handshake per accepted request.
